// File: rtl/lut_mult_sequencer_if.sv
// Operand/result handshakes and LUT drive/return lines for lut_mult_sequencer.
// The slave modport is the sequencer; master is its environment (PE control + LUT).
interface lut_mult_sequencer_if #(
    parameter int A_CHUNKS = 2,
    parameter int B_CHUNKS = 2,
    parameter int ACC_W    = 24
);
    logic                    in_valid;
    logic                    in_ready;
    logic [A_CHUNKS*4-1:0]   in_a;
    logic [B_CHUNKS*4-1:0]   in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_result;
    logic                    busy;
    logic [3:0]              lut_comp1;
    logic [3:0]              lut_comp2;
    logic [2:0]              lut_i;
    logic [2:0]              lut_j;
    logic [20:0]             lut_data;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, lut_data,
        output in_ready, out_valid, out_result, busy,
               lut_comp1, lut_comp2, lut_i, lut_j
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, lut_data,
        input  in_ready, out_valid, out_result, busy,
               lut_comp1, lut_comp2, lut_i, lut_j
    );
endinterface

// File: rtl/lut_mult_sequencer.sv
// Walks every (i, j) 4-bit chunk pair of two operands through the partial-product
// LUT, one pair per cycle, and sums the LUT's registered results into one product.
module lut_mult_sequencer #(
    parameter int A_CHUNKS = 2,
    parameter int B_CHUNKS = 2,
    parameter int ACC_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_mult_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [2:0] I_LAST = 3'(A_CHUNKS - 1);
    localparam logic [2:0] J_LAST = 3'(B_CHUNKS - 1);

    state_t                state_q, state_d;
    logic [A_CHUNKS*4-1:0] a_q, a_d;
    logic [B_CHUNKS*4-1:0] b_q, b_d;
    logic [2:0]            i_q, i_d;
    logic [2:0]            j_q, j_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  tag_q, tag_d;

    logic                  in_ready_s;
    logic                  accept_s;
    logic                  last_j_s;
    logic                  last_pair_s;
    logic [31:0]           a_pad_s;
    logic [31:0]           b_pad_s;

    assign last_j_s    = (j_q == J_LAST);
    assign last_pair_s = last_j_s && (i_q == I_LAST);
    assign accept_s    = bus.in_valid & in_ready_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) state_d = ST_ISSUE;
                else              state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (last_pair_s) state_d = ST_DRAIN;
                else             state_d = ST_ISSUE;
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready && bus.in_valid) state_d = ST_ISSUE;
                else if (bus.out_ready)            state_d = ST_IDLE;
                else                               state_d = ST_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: handshakes and LUT drive
    always_comb begin
        a_pad_s       = 32'(a_q);
        b_pad_s       = 32'(b_q);
        in_ready_s    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.lut_comp1 = 4'd0;
        bus.lut_comp2 = 4'd0;
        bus.lut_i     = 3'd0;
        bus.lut_j     = 3'd0;
        case (state_q)
            ST_IDLE: begin
                in_ready_s = 1'b1;
            end
            ST_ISSUE: begin
                bus.busy      = 1'b1;
                bus.lut_comp1 = a_pad_s[{i_q, 2'b00} +: 4];
                bus.lut_comp2 = b_pad_s[{j_q, 2'b00} +: 4];
                bus.lut_i     = i_q;
                bus.lut_j     = j_q;
            end
            ST_DRAIN: begin
                bus.busy = 1'b1;
            end
            ST_HOLD: begin
                bus.out_valid = 1'b1;
                in_ready_s    = bus.out_ready;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_result = acc_q;

    // Operand capture, chunk-index walk and accumulation of tagged LUT results
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        i_d   = i_q;
        j_d   = j_q;
        acc_d = acc_q;
        // The LUT answers one cycle after each ISSUE cycle; the tag marks that cycle.
        tag_d = (state_q == ST_ISSUE);
        if (accept_s) begin
            a_d   = bus.in_a;
            b_d   = bus.in_b;
            i_d   = 3'd0;
            j_d   = 3'd0;
            acc_d = {ACC_W{1'b0}};
        end else begin
            if (state_q == ST_ISSUE) begin
                if (last_j_s) begin
                    j_d = 3'd0;
                    if (last_pair_s) i_d = 3'd0;
                    else             i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
            end else begin
                j_d = j_q;
            end
            if (tag_q) acc_d = acc_q + ACC_W'(bus.lut_data);
            else       acc_d = acc_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            i_q   <= 3'd0;
            j_q   <= 3'd0;
            acc_q <= '0;
            tag_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            i_q   <= i_d;
            j_q   <= j_d;
            acc_q <= acc_d;
            tag_q <= tag_d;
        end
    end
endmodule
